// File: rtl/spi_sram_pkg.sv
// spi_sram_pkg: FSM states, opcodes and wrap-mode encodings shared by the SPI SRAM responder.
package spi_sram_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WRITE, S_READ, S_MODE_RD, S_MODE_WR, S_IGNORE
   } state_t;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_RDMR = 8'h05;
   localparam logic [7:0] OP_WRMR = 8'h01;
   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_PAGE = 2'b10;
   localparam logic [1:0] MODE_SEQ = 2'b01;
   localparam logic [7:0] MODE_RESET = 8'h40;
   localparam int PAGE_BYTES = 32;
   // 01 and 11 both mean sequential; fold them onto one encoding
   function automatic logic [1:0] wrap_of(input logic [1:0] m);
      return (m == MODE_BYTE || m == MODE_PAGE) ? m : MODE_SEQ;
   endfunction
endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: clk-domain synchronisers for the SPI pins, with edge pulses for sck and cs.
module spi_in_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_sck,
   input  logic spi_cs_n,
   input  logic spi_mosi,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic mosi
);
   logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sck_q <= '0;
         cs_q <= '1;
         mosi_q <= '0;
      end else begin
         sck_q <= {sck_q[SYNC_STAGES-2:0], spi_sck};
         cs_q <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      end
   assign sck_rise = sck_q[SYNC_STAGES-2] & ~sck_q[SYNC_STAGES-1];
   assign sck_fall = ~sck_q[SYNC_STAGES-2] & sck_q[SYNC_STAGES-1];
   assign cs_fall = ~cs_q[SYNC_STAGES-2] & cs_q[SYNC_STAGES-1];
   assign cs_rise = cs_q[SYNC_STAGES-2] & ~cs_q[SYNC_STAGES-1];
   assign mosi = mosi_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_sram_responder.sv
// spi_sram_responder: SPI mode-0 target emulating a 23LC-style serial SRAM over an internal byte array.
// Define SPI_SRAM_RESPONDER_MODE_REG_EN to add the RDMR/WRMR mode register and byte/page wrap modes.
module spi_sram_responder
   import spi_sram_pkg::*;
#(
   parameter int MEM_BYTES = 256,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_sck,
   input  logic spi_cs_n,
   input  logic spi_mosi,
   output logic spi_miso,
   output logic spi_miso_oe,
   output logic busy,
   output logic err_opcode
);
   localparam int AW = $clog2(MEM_BYTES);
   localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);
   state_t state, next, cmd_next;
   logic sck_rise, sck_fall, cs_fall, cs_rise, mosi, last_bit, miso_q, done_q, we;
   logic [3:0] cnt;
   logic [14:0] shift_in;
   logic [7:0] shift_out, opcode, rx_byte, mode;
   logic [1:0] wrap;
   logic [AW-1:0] addr, adv, rx_addr;
   logic [7:0] mem [MEM_BYTES];
   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
      .sck_rise(sck_rise), .sck_fall(sck_fall), .cs_fall(cs_fall), .cs_rise(cs_rise), .mosi(mosi)
   );
`ifdef SPI_SRAM_RESPONDER_MODE_REG_EN
   localparam bit MODE_EN = 1'b1;
   logic [7:0] mode_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mode_q <= MODE_RESET;
      else if (state == S_MODE_WR && sck_rise && last_bit && !cs_rise) mode_q <= rx_byte;
   assign mode = mode_q;
`else
   localparam bit MODE_EN = 1'b0;
   assign mode = MODE_RESET;
`endif
   assign rx_byte = {shift_in[6:0], mosi};
   assign rx_addr = AW'({shift_in, mosi});
   assign last_bit = cnt == (state == S_ADDR ? 4'd15 : 4'd7);
   assign wrap = wrap_of(mode[7:6]);
   assign adv = wrap == MODE_BYTE ? addr
              : wrap == MODE_PAGE ? (addr & ~PAGE_MASK) | ((addr + AW'(1)) & PAGE_MASK)
              : addr + AW'(1);
   // a byte whose 8th bit coincides with cs_rise still commits
   assign we = state == S_WRITE && sck_rise && last_bit && !done_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= next;
   always_comb begin
      cmd_next = (rx_byte == OP_READ || rx_byte == OP_WRITE) ? S_ADDR
               : (MODE_EN && rx_byte == OP_RDMR) ? S_MODE_RD
               : (MODE_EN && rx_byte == OP_WRMR) ? S_MODE_WR : S_IGNORE;
      next = state;
      if (state == S_IDLE) next = cs_fall ? S_CMD : S_IDLE;
      else if (cs_rise) next = S_IDLE;
      else if (sck_rise && last_bit && state == S_CMD) next = cmd_next;
      else if (sck_rise && last_bit && state == S_ADDR) next = opcode == OP_READ ? S_READ : S_WRITE;
   end
   always_comb begin
      busy = state != S_IDLE;
      spi_miso_oe = state == S_READ || state == S_MODE_RD;
      spi_miso = spi_miso_oe & miso_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         shift_in <= '0;
         shift_out <= '0;
         opcode <= '0;
         addr <= '0;
         miso_q <= 1'b0;
         done_q <= 1'b0;
         err_opcode <= 1'b0;
      end else begin
         err_opcode <= 1'b0;
         if (state == S_IDLE || cs_rise) begin
            cnt <= '0;
            miso_q <= 1'b0;
            done_q <= 1'b0;
         end else if (sck_rise) begin
            shift_in <= {shift_in[13:0], mosi};
            cnt <= last_bit ? 4'd0 : cnt + 4'd1;
            if (last_bit && state == S_CMD) begin
               opcode <= rx_byte;
               shift_out <= mode;
               err_opcode <= cmd_next == S_IGNORE;
            end
            if (last_bit && state == S_ADDR) begin
               addr <= rx_addr;
               shift_out <= mem[rx_addr];
            end
            if (last_bit && state == S_READ) begin
               addr <= adv;
               shift_out <= mem[adv];
            end
            if (last_bit && state == S_MODE_RD) shift_out <= mode;
            if (last_bit && state == S_WRITE) begin
               addr <= adv;
               done_q <= done_q | (wrap == MODE_BYTE);
            end
         end else if (sck_fall && spi_miso_oe) begin
            miso_q <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
         end
      end
   always_ff @(posedge clk)
      if (we) mem[addr] <= rx_byte;
endmodule

// File: doc/spi_sram_responder.md
Name: spi_sram_responder

Overview:
- SPI target (mode 0) that emulates a 23LC-style serial SRAM: READ 0x03 / WRITE 0x02, 16-bit byte address, sequential burst.
- Backed by an internal byte array; serves as the far end of the SerV core's SPI memory master, for on-chip loopback and for the verification bench.
- SPI inputs are oversampled in the clk domain; no logic is clocked by spi_sck.

Parameters:
- MEM_BYTES, 256, size of the backing array in bytes; must be a power of two, ≤ 65536.
- SYNC_STAGES, 2, synchroniser depth for spi_sck, spi_cs_n and spi_mosi; must be ≥ 2.

Ports:
- clk  in  1  system clock; must run at ≥ 4× the spi_sck frequency.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_sck  in  1  SPI clock from the initiator; idles low.
- spi_cs_n  in  1  chip select, active-low.
- spi_mosi  in  1  serial data from the initiator.
- spi_miso  out  1  serial data to the initiator.
- spi_miso_oe  out  1  MISO output enable for the pad tri-state.
- busy  out  1  high while a transaction is in progress (spi_cs_n low after sync).
- err_opcode  out  1  one-clk pulse when an unsupported opcode is received.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, busy=0, err_opcode=0, FSM=S_IDLE, bit counter=0, address=0, mode register=0x40. The memory array is not reset.
- Synchronisation: SYNC_STAGES flops per input.
  - sck_rise / sck_fall are single-clk pulses from the last two sck stages.
  - cs_fall / cs_rise are derived the same way from spi_cs_n.
- Mode 0 timing:
  - MOSI (synchronised) is sampled on sck_rise, MSB first.
  - MISO changes on sck_fall. The first read bit is presented on the sck_fall following the last address bit.
- FSM states: S_IDLE, S_CMD, S_ADDR, S_WRITE, S_READ, S_MODE_RD, S_MODE_WR, S_IGNORE.
  - S_IDLE → S_CMD on cs_fall; bit counter cleared.
  - S_CMD: after 8 bits, decode the opcode.
    - 0x02 or 0x03 → S_ADDR.
    - 0x05 → S_MODE_RD; 0x01 → S_MODE_WR (only with the optional feature).
    - Anything else → S_IGNORE, with err_opcode pulsed for 1 clk.
  - S_ADDR: after 16 bits, latch addr = received[15:0] mod MEM_BYTES.
    - Opcode 0x02 → S_WRITE.
    - Opcode 0x03 → S_READ; load shift_out = mem[addr].
  - S_WRITE: each 8th bit writes the byte to mem[addr], then advances addr per the wrap rule.
  - S_READ: each 8th bit advances addr per the wrap rule and reloads shift_out from mem[addr].
  - S_IGNORE: MISO is not driven and MOSI is discarded until cs_rise.
- Wrap rule: addr advances modulo MEM_BYTES (sequential mode). The optional feature adds page and byte modes.
- spi_miso_oe is 1 only in S_READ / S_MODE_RD while CS is active; otherwise it is 0 and spi_miso is held at 0.
- cs_rise in any state → S_IDLE within 1 clk.
  - A partially received write byte is discarded; only complete bytes are committed.
  - busy drops and spi_miso_oe drops in the same clk.
- If sck_rise and cs_rise occur in the same clk, cs_rise wins and the bit is dropped.
- sck edges seen while CS is inactive are ignored.
- A write completing in the same clk as cs_rise is committed.
- Reset asserted mid-transaction returns the block to reset values immediately. Memory contents already written are retained.

Optional Feature:
- Macro: SPI_SRAM_RESPONDER_MODE_REG_EN.
- Enabled:
  - Adds an 8-bit mode register, reset value 0x40.
  - Adds opcodes RDMR 0x05 (shift out the register, repeated while CS stays low) and WRMR 0x01 (the 8th bit latches the register).
  - Mode bits [7:6] select the wrap rule:
    - 00: byte mode. One byte per transaction; further bytes are ignored and reads return the same byte.
    - 10: page mode. Wraps within a 32-byte page: addr[4:0] increments, the upper bits are held.
    - 01 or 11: sequential mode.
- Disabled:
  - 0x01 and 0x05 are unsupported opcodes (S_IGNORE plus err_opcode).
  - The wrap rule is always sequential.

Decomposition:
- Package spi_sram_pkg holds:
  - State enum state_t.
  - Opcode constants OP_READ=8'h03, OP_WRITE=8'h02, OP_RDMR=8'h05, OP_WRMR=8'h01.
  - Mode encodings MODE_BYTE, MODE_PAGE, MODE_SEQ.
  - PAGE_BYTES=32.
- Sub-module spi_in_sync: the synchroniser plus edge detector for sck and cs, and the synchroniser for mosi.

Test Plan:
- WRITE 0x02, addr 0x0010, data DE AD BE EF, then CS high. Follow with READ 0x03 addr 0x0010 and 32 SCK → MISO yields 0xDEADBEEF; spi_miso_oe is high only during the data phase.
- MEM_BYTES=256: WRITE at addr 0x00FF with data 11 22 → READ 0x00FF returns 0x11, and READ 0x0000 returns 0x22.
- WRITE 0x02 addr 0x0020 with data 0xAA, then WRITE addr 0x0020 sending only 5 bits of 0x55 before CS high → READ 0x0020 returns 0xAA.
- Opcode 0x9F → err_opcode pulses once and spi_miso_oe stays 0. A following READ of a known location returns the correct data.
- rst_n low during the 12th bit of a READ data phase → spi_miso=0, spi_miso_oe=0 and busy=0 immediately. After release, a READ returns the previously written data.
- With the macro: WRMR 0x01 data 0x00, then WRITE at 0x0010 with data 01 02 03 → only mem[0x10]=0x01 is written and mem[0x11] is unchanged. RDMR returns 0x00. WRMR 0x80 followed by a WRITE at 0x001F with data 0xA1 0xB2 → 0xB2 lands at 0x0000.
